// File: rtl/lut_sweep_engine.sv
// Serially loaded N_IN-input truth table with single-shot evaluation and an
// exhaustive sweep that streams every entry out and counts the ones.
//
// state   | meaning
// S_IDLE  | accept load_start > start_sweep > in_valid (lower ones dropped)
// S_LOAD  | shift cfg_bit into table[ptr] on each cfg_valid, leave after last entry
// S_SWEEP | stream table[idx] onto y for every idx, accumulate ones
// S_DONE  | one-cycle completion pulse, publish the ones count
module lut_sweep_engine #(
  parameter int N_IN = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_start,
  input  logic            cfg_valid,
  input  logic            cfg_bit,
  output logic            cfg_ready,
  input  logic            in_valid,
  input  logic [N_IN-1:0] in_vec,
  input  logic            start_sweep,
  output logic            y,
  output logic            y_valid,
  output logic [N_IN-1:0] y_idx,
  output logic            busy,
  output logic            done,
  output logic [N_IN:0]   sweep_ones
);

  localparam int DEPTH = 1 << N_IN;
  localparam logic [N_IN-1:0] LAST = {N_IN{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SWEEP,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [DEPTH-1:0]  table_q;
  logic [N_IN-1:0]   ptr_q;
  logic [N_IN-1:0]   idx_q;
  logic [N_IN:0]     acc_q;
  logic [N_IN:0]     sweep_ones_q;
  logic              y_q;
  logic              y_valid_q;
  logic [N_IN-1:0]   y_idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      table_q      <= '0;
      ptr_q        <= '0;
      idx_q        <= '0;
      acc_q        <= '0;
      sweep_ones_q <= '0;
      y_q          <= 1'b0;
      y_valid_q    <= 1'b0;
      y_idx_q      <= '0;
    end else begin
      y_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (load_start) begin
            state_q <= S_LOAD;
            ptr_q   <= '0;
          end else if (start_sweep) begin
            state_q <= S_SWEEP;
            idx_q   <= '0;
            acc_q   <= '0;
          end else if (in_valid) begin
            y_q       <= table_q[in_vec];
            y_idx_q   <= in_vec;
            y_valid_q <= 1'b1;
          end
        end
        S_LOAD: begin
          if (cfg_valid) begin
            table_q[ptr_q] <= cfg_bit;
            ptr_q          <= ptr_q + 1'b1;
            // Last entry written: leave before the pointer can wrap onto entry 0.
            if (ptr_q == LAST) begin
              state_q <= S_IDLE;
            end
          end
        end
        S_SWEEP: begin
          y_q       <= table_q[idx_q];
          y_idx_q   <= idx_q;
          y_valid_q <= 1'b1;
          acc_q     <= acc_q + {{N_IN{1'b0}}, table_q[idx_q]};
          idx_q     <= idx_q + 1'b1;
          if (idx_q == LAST) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          sweep_ones_q <= acc_q;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cfg_ready  = (state_q == S_LOAD);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign y          = y_q;
  assign y_valid    = y_valid_q;
  assign y_idx      = y_idx_q;
  assign sweep_ones = sweep_ones_q;

endmodule

// File: tb/tb_lut_sweep_engine.sv
// Directed bench for lut_sweep_engine (N_IN=5): table-driven evaluations plus
// hand-written load, sweep, priority and reset-abort sequences.
module tb_lut_sweep_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_start;
  logic       cfg_valid;
  logic       cfg_bit;
  logic       cfg_ready;
  logic       in_valid;
  logic [4:0] in_vec;
  logic       start_sweep;
  logic       y;
  logic       y_valid;
  logic [4:0] y_idx;
  logic       busy;
  logic       done;
  logic [5:0] sweep_ones;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [31:0] tbl;
    logic [4:0]  vec;
    logic        exp_y;
  } vec_t;

  vec_t vecs [14];

  lut_sweep_engine #(.N_IN(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .cfg_valid  (cfg_valid),
    .cfg_bit    (cfg_bit),
    .cfg_ready  (cfg_ready),
    .in_valid   (in_valid),
    .in_vec     (in_vec),
    .start_sweep(start_sweep),
    .y          (y),
    .y_valid    (y_valid),
    .y_idx      (y_idx),
    .busy       (busy),
    .done       (done),
    .sweep_ones (sweep_ones)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_y"},          32'(y),          0);
    chk({tag, "_y_valid"},    32'(y_valid),    0);
    chk({tag, "_y_idx"},      32'(y_idx),      0);
    chk({tag, "_cfg_ready"},  32'(cfg_ready),  0);
    chk({tag, "_busy"},       32'(busy),       0);
    chk({tag, "_done"},       32'(done),       0);
    chk({tag, "_sweep_ones"}, 32'(sweep_ones), 0);
  endtask

  // Bit k of w goes to entry k; optional idle gaps; one extra cfg bit after the last.
  task automatic load_table(input logic [31:0] w, input bit gaps);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("load_cfg_ready", 32'(cfg_ready), 1);
    chk("load_busy",      32'(busy),      1);
    for (int k = 0; k < 32; k++) begin
      if (gaps && (k % 7 == 3)) begin
        cfg_valid = 1'b0;
        tick();
      end
      cfg_valid = 1'b1;
      cfg_bit   = w[k];
      tick();
    end
    cfg_bit = ~w[0];
    chk("load_end_cfg_ready", 32'(cfg_ready), 0);
    chk("load_end_busy",      32'(busy),      0);
    tick();
    cfg_valid = 1'b0;
    cfg_bit   = 1'b0;
  endtask

  task automatic eval(input logic [4:0] v, input logic exp_y, input string name);
    in_valid = 1'b1;
    in_vec   = v;
    tick();
    in_valid = 1'b0;
    chk({name, "_y_valid"}, 32'(y_valid), 1);
    chk({name, "_y"},       32'(y),       32'(exp_y));
    chk({name, "_y_idx"},   32'(y_idx),   32'(v));
    tick();
    chk({name, "_y_valid_drop"}, 32'(y_valid), 0);
  endtask

  task automatic sweep(input logic [31:0] w, input int exp_ones, input bit poke);
    start_sweep = 1'b1;
    tick();
    start_sweep = 1'b0;
    chk("sweep_busy",        32'(busy),    1);
    chk("sweep_first_valid", 32'(y_valid), 0);
    for (int i = 0; i < 34; i++) begin
      in_valid = poke && (i < 30);
      in_vec   = 5'(i);
      tick();
      chk($sformatf("sweep_y_valid_%0d", i), 32'(y_valid), (i < 32) ? 1 : 0);
      chk($sformatf("sweep_done_%0d", i),    32'(done),    (i == 31) ? 1 : 0);
      if (i < 32) begin
        chk($sformatf("sweep_y_idx_%0d", i), 32'(y_idx), i);
        chk($sformatf("sweep_y_%0d", i),     32'(y),     32'(w[i]));
      end
    end
    in_valid = 1'b0;
    chk("sweep_ones", 32'(sweep_ones), exp_ones);
    chk("sweep_end_busy", 32'(busy), 0);
  endtask

  initial begin
    int bad;
    vecs[0]  = '{32'h8000_0001, 5'd0,  1'b1};
    vecs[1]  = '{32'h8000_0001, 5'd31, 1'b1};
    vecs[2]  = '{32'h8000_0001, 5'd5,  1'b0};
    vecs[3]  = '{32'h1234_5678, 5'd3,  1'b1};
    vecs[4]  = '{32'h1234_5678, 5'd0,  1'b0};
    vecs[5]  = '{32'h1234_5678, 5'd7,  1'b0};
    vecs[6]  = '{32'h1234_5678, 5'd28, 1'b1};
    vecs[7]  = '{32'h1234_5678, 5'd29, 1'b0};
    vecs[8]  = '{32'hA5A5_A5A5, 5'd0,  1'b1};
    vecs[9]  = '{32'hA5A5_A5A5, 5'd1,  1'b0};
    vecs[10] = '{32'hA5A5_A5A5, 5'd2,  1'b1};
    vecs[11] = '{32'hA5A5_A5A5, 5'd8,  1'b1};
    vecs[12] = '{32'hA5A5_A5A5, 5'd31, 1'b1};
    vecs[13] = '{32'hA5A5_A5A5, 5'd30, 1'b0};

    rst = 1'b1; load_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
    in_valid = 1'b0; in_vec = '0; start_sweep = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    for (int e = 0; e < 14; e++) begin
      if (e == 0 || vecs[e].tbl != vecs[e-1].tbl) load_table(vecs[e].tbl, (e % 2) == 1);
      eval(vecs[e].vec, vecs[e].exp_y, $sformatf("eval%0d", e));
    end

    // All ones; stray cfg_valid in IDLE must not touch the table.
    load_table(32'hFFFF_FFFF, 1'b0);
    cfg_valid = 1'b1;
    cfg_bit   = 1'b0;
    repeat (3) tick();
    cfg_valid = 1'b0;
    sweep(32'hFFFF_FFFF, 32, 1'b1);
    chk("post_sweep_no_extra_valid", 32'(y_valid), 0);

    load_table(32'h8000_0000, 1'b1);
    chk("load_keeps_sweep_ones", 32'(sweep_ones), 32);
    sweep(32'h8000_0000, 1, 1'b0);

    // load_start wins over start_sweep.
    load_start  = 1'b1;
    start_sweep = 1'b1;
    tick();
    load_start  = 1'b0;
    start_sweep = 1'b0;
    chk("prio_cfg_ready", 32'(cfg_ready), 1);
    bad = 0;
    for (int k = 0; k < 32; k++) begin
      cfg_valid = 1'b1;
      cfg_bit   = (k < 16);
      tick();
      if (done !== 1'b0 || y_valid !== 1'b0) bad++;
    end
    cfg_valid = 1'b0;
    chk("prio_no_sweep_activity", 32'(bad), 0);
    chk("prio_busy", 32'(busy), 0);
    chk("prio_sweep_ones_kept", 32'(sweep_ones), 1);
    eval(5'd15, 1'b1, "prio_e15");
    eval(5'd16, 1'b0, "prio_e16");

    // Reset mid-LOAD after 10 bits.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cfg_valid = 1'b1;
      cfg_bit   = 1'b1;
      tick();
    end
    #3 rst = 1'b1;
    #1;
    chk_all_zero("rst_load");
    cfg_valid = 1'b0;
    #2 rst = 1'b0;
    tick();
    chk("rst_load_busy",      32'(busy),      0);
    chk("rst_load_cfg_ready", 32'(cfg_ready), 0);
    eval(5'd0,  1'b0, "rst_e0");
    eval(5'd9,  1'b0, "rst_e9");
    eval(5'd15, 1'b0, "rst_e15");
    eval(5'd31, 1'b0, "rst_e31");

    // Reset mid-SWEEP: no partial count survives into the next sweep.
    load_table(32'hFFFF_FFFF, 1'b0);
    start_sweep = 1'b1;
    tick();
    start_sweep = 1'b0;
    repeat (5) tick();
    #3 rst = 1'b1;
    #1;
    chk_all_zero("rst_sweep");
    #2 rst = 1'b0;
    tick();
    sweep(32'h0000_0000, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lut_sweep_engine.md
LUT_SWEEP_ENGINE -- requirements
Module: lut_sweep_engine

Interface
REQ-001 Parameter: N_IN, default 5, legal range 2..8; number of Boolean inputs; the truth table holds 2^N_IN bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 load_start  input  1  pulse; requests a truth-table load.
REQ-005 cfg_valid  input  1  serial table bit present.
REQ-006 cfg_bit  input  1  serial table bit; the k-th accepted bit is written to table entry k.
REQ-007 cfg_ready  output  1  high only in LOAD.
REQ-008 in_valid  input  1  single-evaluation request.
REQ-009 in_vec  input  N_IN  input vector to evaluate; bit N_IN-1 is the MSB of the table index.
REQ-010 start_sweep  input  1  pulse; requests an exhaustive sweep.
REQ-011 y  output  1  registered function output.
REQ-012 y_valid  output  1  y is valid this cycle.
REQ-013 y_idx  output  N_IN  table index that produced the current y.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 done  output  1  one-cycle pulse at sweep completion.
REQ-016 sweep_ones  output  N_IN+1  count of table entries equal to 1 from the last sweep.

Function
REQ-017 The block SHALL implement states IDLE, LOAD, SWEEP and DONE.
REQ-018 In IDLE, inputs SHALL be served with priority load_start > start_sweep > in_valid; lower-priority requests in the same cycle SHALL be dropped.
REQ-019 IDLE->LOAD SHALL occur on load_start, with the load pointer cleared to 0.
REQ-020 In LOAD, each cycle with cfg_valid=1 SHALL write cfg_bit to table entry ptr and increment ptr.
REQ-021 The write at ptr=2^N_IN-1 SHALL end the load, with the next state IDLE; no wrap-around write SHALL occur.
REQ-022 cfg_valid outside LOAD SHALL be ignored.
REQ-023 In IDLE, in_valid=1 SHALL produce y=table[in_vec], y_idx=in_vec and y_valid=1 on the next cycle (latency 1).
REQ-024 Outside that case, y_valid SHALL be 0 except as given in REQ-026.
REQ-025 IDLE->SWEEP SHALL occur on start_sweep, with idx cleared to 0 and the ones accumulator cleared.
REQ-026 In SWEEP, every cycle SHALL:
 - present table[idx] on y, idx on y_idx and y_valid=1 on the following cycle;
 - add table[idx] to the accumulator;
 - increment idx.
REQ-027 After idx=2^N_IN-1 is processed, the next state SHALL be DONE; SWEEP SHALL last exactly 2^N_IN cycles.
REQ-028 DONE SHALL last one cycle, assert done=1, load sweep_ones with the final count, and return to IDLE.
REQ-029 sweep_ones SHALL hold its value until the next DONE or reset; N_IN+1 bits SHALL represent 2^N_IN without overflow.
REQ-030 load_start, start_sweep and in_valid SHALL be ignored while busy=1.
REQ-031 A table load SHALL NOT alter sweep_ones.

Reset
REQ-032 While rst=1, asynchronously:
 - state=IDLE, ptr=0, idx=0;
 - all table entries=0;
 - y=0, y_valid=0, y_idx=0;
 - cfg_ready=0, busy=0, done=0, sweep_ones=0.
REQ-033 Reset asserted mid-LOAD or mid-SWEEP SHALL abort the operation with no partial result retained.

Verification (N_IN=5)
REQ-034 Assert rst mid-cycle -> all outputs 0 immediately; after release busy=0 and cfg_ready=0.
REQ-035 Load 32 bits 0x80000001 (bit k first = entry k), then eval in_vec=0, 31, 5 -> y=1, 1, 0 respectively, each one cycle after in_valid, with y_idx matching.
REQ-036 Load all ones, pulse start_sweep:
 - y_valid high for 32 consecutive cycles with y_idx 0..31;
 - done pulses once;
 - sweep_ones=6'd32.
REQ-037 Load a table with only entry 31 set (5-input AND), then sweep -> y=1 only at y_idx=31; sweep_ones=1.
REQ-038 Assert rst after 10 LOAD bits -> busy=0 and every subsequent eval returns y=0.
REQ-039 Drive load_start and start_sweep together in IDLE -> LOAD entered, no sweep, done stays 0; in_valid pulsed during SWEEP -> no extra y_valid beyond the 32 sweep outputs.
